// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one APU between NUM_CORES cores: round-robin request arbitration with lock-until-grant,
// plus an in-order ID FIFO that steers each APU response back to the core that issued it.
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES        = 2,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int DATA_W           = 32,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_CORES-1:0]                       core_req_i,
    output logic [NUM_CORES-1:0]                       core_gnt_o,
    input  logic [NUM_CORES*APU_NARGS_CPU*DATA_W-1:0]  core_operands_i,
    input  logic [NUM_CORES*APU_WOP_CPU-1:0]           core_op_i,
    input  logic [NUM_CORES*APU_NDSFLAGS_CPU-1:0]      core_flags_i,
    output logic [NUM_CORES-1:0]                       core_rvalid_o,
    output logic [DATA_W-1:0]                          core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                core_flags_o,
    output logic                                       apu_req_o,
    input  logic                                       apu_gnt_i,
    output logic [APU_NARGS_CPU*DATA_W-1:0]            apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                     apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                apu_flags_o,
    input  logic                                       apu_rvalid_i,
    input  logic [DATA_W-1:0]                          apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                apu_flags_i,
    output logic                                       busy_o,
    output logic                                       err_o
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OPS_W = APU_NARGS_CPU * DATA_W;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] locked_idx;
    logic             lock;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] sel_next;
    int               scan_idx;

    logic [IDX_W-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] head;
    logic             err_q;

    // Scan from the highest offset down so the lowest offset past rr_ptr wins.
    always_comb begin
        sel      = rr_ptr;
        scan_idx = 0;
        if (lock) begin
            sel = locked_idx;
        end else begin
            for (int k = NUM_CORES - 1; k >= 0; k--) begin
                scan_idx = (int'(rr_ptr) + k) % NUM_CORES;
                if (core_req_i[scan_idx]) sel = IDX_W'(scan_idx);
            end
        end
    end

    assign sel_next  = (sel == IDX_W'(NUM_CORES - 1)) ? '0 : sel + 1'b1;

    assign full      = (count == (PTR_W+1)'(MAX_OUTSTANDING));
    assign empty     = (count == '0);
    assign apu_req_o = (|core_req_i) & ~full;
    assign handshake = apu_req_o & apu_gnt_i;
    assign pop       = apu_rvalid_i & ~empty;
    assign head      = id_fifo[rd_ptr];

    assign apu_operands_o = core_operands_i[sel*OPS_W +: OPS_W];
    assign apu_op_o       = core_op_i[sel*APU_WOP_CPU +: APU_WOP_CPU];
    assign apu_flags_o    = core_flags_i[sel*APU_NDSFLAGS_CPU +: APU_NDSFLAGS_CPU];

    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        if (handshake) core_gnt_o[sel] = 1'b1;
        if (pop)       core_rvalid_o[head] = 1'b1;
    end

    assign core_result_o = apu_result_i;
    assign core_flags_o  = apu_flags_i;
    assign busy_o        = ~empty;
    assign err_o         = err_q;

    // ID storage is data only; validity is tracked by count and the pointers.
    always_ff @(posedge clk_i) begin
        if (handshake) id_fifo[wr_ptr] <= sel;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= sel_next;
                lock   <= 1'b0;
                wr_ptr <= wr_ptr + 1'b1;
            end else if (apu_req_o) begin
                lock       <= 1'b1;
                locked_idx <= sel;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({handshake, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (apu_rvalid_i && empty) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for cv32e40p_apu_arbiter: arbitration, lock, ID FIFO steering, full and error cases.
module tb_cv32e40p_apu_arbiter;

    localparam int NC = 2;
    localparam int MO = 4;
    localparam int DW = 32;
    localparam int NA = 3;
    localparam int WOP = 6;
    localparam int NDS = 15;
    localparam int NUS = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NC-1:0]          core_req;
    logic [NC-1:0]          core_gnt;
    logic [NC*NA*DW-1:0]    core_operands;
    logic [NC*WOP-1:0]      core_op;
    logic [NC*NDS-1:0]      core_flags;
    logic [NC-1:0]          core_rvalid;
    logic [DW-1:0]          core_result;
    logic [NUS-1:0]         core_flags_out;
    logic                   apu_req;
    logic                   apu_gnt;
    logic [NA*DW-1:0]       apu_operands;
    logic [WOP-1:0]         apu_op;
    logic [NDS-1:0]         apu_flags;
    logic                   apu_rvalid;
    logic [DW-1:0]          apu_result;
    logic [NUS-1:0]         apu_flags_in;
    logic                   busy;
    logic                   err;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [NA*DW-1:0] OPS0 = 96'h1111_0000_2222_0000_3333_0000;
    localparam logic [NA*DW-1:0] OPS1 = 96'hAAAA_5555_BBBB_6666_CCCC_7777;
    localparam logic [WOP-1:0]   OP0  = 6'h15;
    localparam logic [WOP-1:0]   OP1  = 6'h2A;
    localparam logic [NDS-1:0]   FL0  = 15'h0123;
    localparam logic [NDS-1:0]   FL1  = 15'h7ABC;

    cv32e40p_apu_arbiter #(
        .NUM_CORES(NC), .MAX_OUTSTANDING(MO), .DATA_W(DW), .APU_NARGS_CPU(NA),
        .APU_WOP_CPU(WOP), .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_gnt_o(core_gnt),
        .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
        .core_rvalid_o(core_rvalid), .core_result_o(core_result), .core_flags_o(core_flags_out),
        .apu_req_o(apu_req), .apu_gnt_i(apu_gnt),
        .apu_operands_o(apu_operands), .apu_op_o(apu_op), .apu_flags_o(apu_flags),
        .apu_rvalid_i(apu_rvalid), .apu_result_i(apu_result), .apu_flags_i(apu_flags_in),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * MO && busy; i++) begin
            apu_rvalid = 1'b1;
            tick();
        end
        apu_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        apu_result   = 32'h1234_5678;
        apu_flags_in = 5'h0A;
        do_reset();
        #2;
        total_cnt++; if (core_gnt !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", core_gnt); else pass_cnt++;
        total_cnt++; if (core_rvalid !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", core_rvalid); else pass_cnt++;
        total_cnt++; if (apu_req !== 1'b0) $display("FAIL reset_apu_req got=%b exp=0", apu_req); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL reset_busy_err got=%b%b exp=00", busy, err); else pass_cnt++;
        total_cnt++; if (apu_op !== OP0 || apu_operands !== OPS0 || apu_flags !== FL0)
            $display("FAIL reset_mux got op=%h exp op=%h", apu_op, OP0); else pass_cnt++;
        total_cnt++; if (core_result !== 32'h1234_5678 || core_flags_out !== 5'h0A)
            $display("FAIL reset_result got=%h/%h exp=12345678/0a", core_result, core_flags_out); else pass_cnt++;
        tick();
    endtask

    task automatic test_single();
        core_req = 2'b01; apu_gnt = 1'b1;
        #2;
        total_cnt++; if (core_gnt !== 2'b01) $display("FAIL single_gnt got=%b exp=01", core_gnt); else pass_cnt++;
        total_cnt++; if (apu_op !== OP0 || apu_operands !== OPS0) $display("FAIL single_mux got op=%h exp=%h", apu_op, OP0); else pass_cnt++;
        tick();
        core_req = 2'b00; apu_gnt = 1'b0;
        #2;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else pass_cnt++;
        tick(); tick();
        apu_rvalid = 1'b1; apu_result = 32'hDEADBEEF; apu_flags_in = 5'h13;
        #2;
        total_cnt++; if (core_rvalid !== 2'b01) $display("FAIL single_rvalid got=%b exp=01", core_rvalid); else pass_cnt++;
        total_cnt++; if (core_result !== 32'hDEADBEEF || core_flags_out !== 5'h13)
            $display("FAIL single_result got=%h/%h exp=deadbeef/13", core_result, core_flags_out); else pass_cnt++;
        tick();
        apu_rvalid = 1'b0;
        #2;
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL single_err got=%b exp=0", err); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_req = 2'b11; apu_gnt = 1'b1;
            #2;
            total_cnt++; if (core_gnt !== exp_seq[i]) $display("FAIL b2b_gnt%0d got=%b exp=%b", i, core_gnt, exp_seq[i]); else pass_cnt++;
            tick();
        end
        core_req = 2'b00; apu_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apu_rvalid = 1'b1; apu_result = 32'hC0DE_0000 + i;
            #2;
            total_cnt++; if (core_rvalid !== exp_seq[i]) $display("FAIL b2b_rvalid%0d got=%b exp=%b", i, core_rvalid, exp_seq[i]); else pass_cnt++;
            tick();
        end
        apu_rvalid = 1'b0;
        #2;
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_lock();
        do_reset();
        // Core 1 alone requests and is stalled; core 0 joining must not steal the locked channel.
        core_req = 2'b10; apu_gnt = 1'b0;
        #2;
        total_cnt++; if (apu_op !== OP1) $display("FAIL lock_sel1 got=%h exp=%h", apu_op, OP1); else pass_cnt++;
        tick();
        core_req = 2'b11;
        #2;
        total_cnt++; if (apu_op !== OP1 || apu_flags !== FL1) $display("FAIL lock_hold got=%h exp=%h", apu_op, OP1); else pass_cnt++;
        total_cnt++; if (core_gnt !== 2'b00) $display("FAIL lock_nognt got=%b exp=00", core_gnt); else pass_cnt++;
        tick();
        apu_gnt = 1'b1;
        #2;
        total_cnt++; if (core_gnt !== 2'b10) $display("FAIL lock_gnt got=%b exp=10", core_gnt); else pass_cnt++;
        tick();
        core_req = 2'b01;
        tick();
        core_req = 2'b11; apu_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apu_gnt = (i == 3);
            #2;
            total_cnt++; if (apu_op !== OP1 || apu_operands !== OPS1) $display("FAIL rr_op%0d got=%h exp=%h", i, apu_op, OP1); else pass_cnt++;
            total_cnt++; if (core_gnt !== ((i == 3) ? 2'b10 : 2'b00)) $display("FAIL rr_gnt%0d got=%b", i, core_gnt); else pass_cnt++;
            tick();
        end
        apu_gnt = 1'b1;
        #2;
        total_cnt++; if (core_gnt !== 2'b01) $display("FAIL rr_wrap got=%b exp=01", core_gnt); else pass_cnt++;
        tick();
        core_req = 2'b00; apu_gnt = 1'b0;
        drain();
    endtask

    task automatic test_full();
        do_reset();
        core_req = 2'b01; apu_gnt = 1'b1;
        for (int i = 0; i < MO; i++) tick();
        #2;
        total_cnt++; if (apu_req !== 1'b0 || core_gnt !== 2'b00) $display("FAIL full_block got req=%b gnt=%b exp 0/00", apu_req, core_gnt); else pass_cnt++;
        apu_rvalid = 1'b1;
        #2;
        total_cnt++; if (apu_req !== 1'b0) $display("FAIL full_pop_req got=%b exp=0", apu_req); else pass_cnt++;
        total_cnt++; if (core_rvalid !== 2'b01) $display("FAIL full_pop_rvalid got=%b exp=01", core_rvalid); else pass_cnt++;
        tick();
        apu_rvalid = 1'b0;
        #2;
        total_cnt++; if (apu_req !== 1'b1 || core_gnt !== 2'b01) $display("FAIL full_reopen got req=%b gnt=%b exp 1/01", apu_req, core_gnt); else pass_cnt++;
        tick();
        core_req = 2'b00; apu_gnt = 1'b0;
        drain();
        #2;
        total_cnt++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL full_drain got err=%b busy=%b", err, busy); else pass_cnt++;
    endtask

    task automatic test_err();
        do_reset();
        apu_rvalid = 1'b1;
        #2;
        total_cnt++; if (core_rvalid !== 2'b00) $display("FAIL err_rvalid got=%b exp=00", core_rvalid); else pass_cnt++;
        tick();
        apu_rvalid = 1'b0;
        #2;
        total_cnt++; if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err); else pass_cnt++;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++; if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err); else pass_cnt++;
        do_reset();
        #2;
        total_cnt++; if (err !== 1'b0) $display("FAIL err_clear got=%b exp=0", err); else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        core_req = 2'b01; apu_gnt = 1'b1;
        tick(); tick();
        core_req = 2'b00; apu_gnt = 1'b0;
        #2;
        total_cnt++; if (busy !== 1'b1) $display("FAIL inflight_busy got=%b exp=1", busy); else pass_cnt++;
        do_reset();
        #2;
        total_cnt++; if (busy !== 1'b0) $display("FAIL inflight_clear got=%b exp=0", busy); else pass_cnt++;
        apu_rvalid = 1'b1;
        #2;
        total_cnt++; if (core_rvalid !== 2'b00) $display("FAIL late_rvalid got=%b exp=00", core_rvalid); else pass_cnt++;
        tick();
        apu_rvalid = 1'b0;
        #2;
        total_cnt++; if (err !== 1'b1) $display("FAIL late_err got=%b exp=1", err); else pass_cnt++;
        core_req = 2'b11; apu_gnt = 1'b1;
        #2;
        total_cnt++; if (core_gnt !== 2'b01) $display("FAIL rrptr_reset got=%b exp=01", core_gnt); else pass_cnt++;
        tick();
        core_req = 2'b00; apu_gnt = 1'b0;
        drain();
    endtask

    initial begin
        rst           = 1'b1;
        core_req      = '0;
        apu_gnt       = 1'b0;
        apu_rvalid    = 1'b0;
        apu_result    = '0;
        apu_flags_in  = '0;
        core_operands = {OPS1, OPS0};
        core_op       = {OP1, OP0};
        core_flags    = {FL1, FL0};
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_lock();
        test_full();
        test_err();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
